// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl: UART debug controller that loads instruction memory, runs or
// single-steps the CPU, then dumps PC, register file and data memory over UART.
module debug_unit_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int IMEM_ADDR_W     = 6,
  parameter int NREGS           = 32,
  parameter int NMEM            = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_rx_done,
  input  logic [DATA_WIDTH_UART-1:0] i_rx_data,
  input  logic                       i_tx_done,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_data,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_W-1:0]     o_imem_addr,
  output logic [DATA_WIDTH-1:0]      o_imem_wdata,
  output logic                       o_cpu_enable,
  input  logic                       i_halt,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [4:0]                 o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic [4:0]                 o_mem_addr,
  input  logic [DATA_WIDTH-1:0]      i_mem_data,
  output logic                       o_busy
);
  localparam int NWORDS = 1 + NREGS + NMEM;
  localparam int WI_W = $clog2(NWORDS);
  localparam int PW = DATA_WIDTH - DATA_WIDTH_UART;
  localparam logic [WI_W-1:0] W_FIRST_MEM = WI_W'(NREGS + 1);
  localparam logic [WI_W-1:0] W_LAST = WI_W'(NWORDS - 1);
  localparam logic [IMEM_ADDR_W-1:0] A_LAST = '1;

  typedef enum logic [2:0] {S_LOAD, S_WAIT_CMD, S_RUN, S_STEP, S_DUMP, S_FINISHED} state_t;

  state_t                  r_state, w_next;
  logic [1:0]              r_byte_cnt;
  logic [PW-1:0]           r_word;
  logic [IMEM_ADDR_W-1:0]  r_imem_addr;
  logic [WI_W-1:0]         r_word_idx;
  logic                    r_halt_seen, r_tx_pending;
  logic [DATA_WIDTH-1:0]   r_pc, w_imem_word, w_dump_word;
  logic                    w_load_we, w_tx_ack, w_last_byte, w_dump_entry, w_dump;

  assign w_dump       = r_state == S_DUMP;
  assign w_imem_word  = {i_rx_data, r_word};
  assign w_load_we    = r_state == S_LOAD && i_rx_done && r_byte_cnt == 2'd3;
  assign w_tx_ack     = w_dump && r_tx_pending && i_tx_done;
  assign w_last_byte  = w_tx_ack && r_byte_cnt == 2'd3 && r_word_idx == W_LAST;
  assign w_dump_entry = (r_state == S_RUN || r_state == S_STEP) && w_next == S_DUMP;
  // Word 0 is the captured PC, then registers, then data memory
  assign w_dump_word  = r_word_idx == '0 ? r_pc : r_word_idx < W_FIRST_MEM ? i_reg_data : i_mem_data;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:     if (w_load_we && (w_imem_word[DATA_WIDTH-1 -: 6] == 6'b111111 || r_imem_addr == A_LAST)) w_next = S_WAIT_CMD;
      S_WAIT_CMD: if (i_rx_done) w_next = i_rx_data == '0 ? S_RUN : i_rx_data == DATA_WIDTH_UART'(1) ? S_STEP : S_WAIT_CMD;
      S_RUN:      if (i_halt) w_next = S_DUMP;
      S_STEP:     w_next = S_DUMP;
      S_DUMP:     if (w_last_byte) w_next = r_halt_seen ? S_FINISHED : S_WAIT_CMD;
      default:    ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      r_state      <= S_LOAD;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_imem_addr  <= '0;
      r_word_idx   <= '0;
      r_halt_seen  <= 1'b0;
      r_tx_pending <= 1'b0;
      r_pc         <= '0;
    end else begin
      r_state <= w_next;
      if (w_dump_entry) begin
        r_pc         <= i_pc;
        r_halt_seen  <= i_halt;
        r_byte_cnt   <= '0;
        r_word_idx   <= '0;
        r_tx_pending <= 1'b0;
      end else if (r_state == S_LOAD && i_rx_done) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_word     <= {i_rx_data, r_word[PW-1:DATA_WIDTH_UART]};
        if (w_load_we && r_imem_addr != A_LAST) r_imem_addr <= r_imem_addr + IMEM_ADDR_W'(1);
      end else if (w_dump) begin
        if (!r_tx_pending) r_tx_pending <= 1'b1;
        else if (i_tx_done) begin
          r_tx_pending <= 1'b0;
          r_byte_cnt   <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) r_word_idx <= r_word_idx + WI_W'(1);
        end
      end
    end

  assign o_tx_signal  = w_dump && !r_tx_pending;
  assign o_tx_data    = w_dump ? w_dump_word[DATA_WIDTH_UART*r_byte_cnt +: DATA_WIDTH_UART] : '0;
  assign o_imem_we    = w_load_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = w_load_we ? w_imem_word : '0;
  assign o_cpu_enable = (r_state == S_RUN && !i_halt) || r_state == S_STEP;
  assign o_reg_addr   = (w_dump && r_word_idx != '0 && r_word_idx < W_FIRST_MEM) ? 5'(r_word_idx - WI_W'(1)) : '0;
  assign o_mem_addr   = (w_dump && r_word_idx >= W_FIRST_MEM) ? 5'(r_word_idx - W_FIRST_MEM) : '0;
  assign o_busy       = i_reset && r_state != S_WAIT_CMD && r_state != S_FINISHED;
endmodule

// File: tb/tb_debug_unit_ctrl.sv
// tb_debug_unit_ctrl: directed table-driven bench for debug_unit_ctrl, with a
// second instance at IMEM_ADDR_W=2 for the address-limit case.
module tb_debug_unit_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset = 1'b0, i_rx_done = 1'b0, i_tx_done = 1'b0, i_halt = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic [31:0] i_pc = 32'h38;
  logic        o_tx_signal, o_imem_we, o_cpu_enable, o_busy;
  logic [7:0]  o_tx_data;
  logic [5:0]  o_imem_addr;
  logic [31:0] o_imem_wdata, i_reg_data, i_mem_data;
  logic [4:0]  o_reg_addr, o_mem_addr;

  logic        b_rx_done = 1'b0, b_tx_signal, b_imem_we, b_cpu_enable, b_busy;
  logic [7:0]  b_rx_data = '0, b_tx_data;
  logic [1:0]  b_imem_addr;
  logic [31:0] b_imem_wdata;
  logic [4:0]  b_reg_addr, b_mem_addr;

  int checks = 0, errors = 0, tx_delay = 1, en_cnt = 0, overlap = 0, unstable = 0;
  logic       tx_open = 1'b0;
  logic [7:0] tx_hold;
  logic [7:0]  tx_q[$];
  logic [5:0]  we_addr[$];
  logic [31:0] we_data[$], b_we_data[$];
  logic [1:0]  b_we_addr[$];

  typedef struct {
    logic [7:0]  rx;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        busy;
  } vec_t;
  vec_t vecs[13];

  function automatic logic [31:0] f_reg(input int k);
    return (k == 5) ? 32'hDEADBEEF : {8'hA0, 8'(k), 8'(3 * k), 8'(~k)};
  endfunction
  function automatic logic [31:0] f_mem(input int k);
    return {8'hB0, 8'(k), 8'(k + 7), 8'h5A};
  endfunction
  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    int k;
    k = n / 4;
    w = (k == 0) ? 32'h38 : (k <= 32) ? f_reg(k - 1) : f_mem(k - 33);
    return w[8*(n%4) +: 8];
  endfunction
  function automatic logic [63:0] outs();
    return {4'b0, o_tx_signal, o_tx_data, o_imem_we, o_imem_addr, o_imem_wdata,
            o_cpu_enable, o_reg_addr, o_mem_addr, o_busy};
  endfunction

  assign i_reg_data = f_reg(int'(o_reg_addr));
  assign i_mem_data = f_mem(int'(o_mem_addr));

  debug_unit_ctrl dut (
    .i_clock(clk), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .i_tx_done(i_tx_done), .o_tx_signal(o_tx_signal), .o_tx_data(o_tx_data),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_cpu_enable(o_cpu_enable), .i_halt(i_halt), .i_pc(i_pc), .o_reg_addr(o_reg_addr),
    .i_reg_data(i_reg_data), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data), .o_busy(o_busy)
  );

  debug_unit_ctrl #(.IMEM_ADDR_W(2)) dut_b (
    .i_clock(clk), .i_reset(i_reset), .i_rx_done(b_rx_done), .i_rx_data(b_rx_data),
    .i_tx_done(1'b0), .o_tx_signal(b_tx_signal), .o_tx_data(b_tx_data),
    .o_imem_we(b_imem_we), .o_imem_addr(b_imem_addr), .o_imem_wdata(b_imem_wdata),
    .o_cpu_enable(b_cpu_enable), .i_halt(1'b0), .i_pc(32'h0), .o_reg_addr(b_reg_addr),
    .i_reg_data(32'h0), .o_mem_addr(b_mem_addr), .i_mem_data(32'h0), .o_busy(b_busy)
  );

  always @(negedge clk) begin
    if (o_imem_we) begin we_addr.push_back(o_imem_addr); we_data.push_back(o_imem_wdata); end
    if (b_imem_we) begin b_we_addr.push_back(b_imem_addr); b_we_data.push_back(b_imem_wdata); end
    if (o_cpu_enable) en_cnt++;
    if (!i_reset) tx_open = 1'b0;
    else if (o_tx_signal) begin
      if (tx_open) overlap++;
      tx_q.push_back(o_tx_data);
      tx_open = 1'b1;
      tx_hold = o_tx_data;
    end else if (tx_open && o_tx_data !== tx_hold) unstable++;
    if (i_tx_done) tx_open = 1'b0;
  end

  // UART transmitter stand-in: acknowledge each byte tx_delay cycles later
  initial forever begin
    @(negedge clk);
    if (o_tx_signal) begin
      repeat (tx_delay) @(posedge clk);
      #1 i_tx_done = 1'b1;
      @(posedge clk);
      #1 i_tx_done = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 i_rx_done = 1'b1; i_rx_data = b;
    @(posedge clk);
    #1 i_rx_done = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(posedge clk);
    #1 b_rx_done = 1'b1; b_rx_data = b;
    @(posedge clk);
    #1 b_rx_done = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(posedge clk);
    #1 i_reset = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < limit) begin @(negedge clk); n++; end
    check(name, o_busy, 0);
  endtask

  task automatic check_dump(input string name, input int n);
    int bad = 0;
    check({name, "_count"}, tx_q.size(), n);
    for (int i = 0; i < tx_q.size() && i < n; i++) if (tx_q[i] !== exp_byte(i)) bad++;
    check({name, "_bytes"}, bad, 0);
  endtask

  initial begin
    int n, sz, bad;
    vecs[0]  = '{8'h21, 1'b0, 6'd0, 32'h0,        1'b1};
    vecs[1]  = '{8'h18, 1'b0, 6'd0, 32'h0,        1'b1};
    vecs[2]  = '{8'h22, 1'b0, 6'd0, 32'h0,        1'b1};
    vecs[3]  = '{8'h00, 1'b1, 6'd0, 32'h00221821, 1'b1};
    vecs[4]  = '{8'h04, 1'b0, 6'd0, 32'h0,        1'b1};
    vecs[5]  = '{8'h00, 1'b0, 6'd0, 32'h0,        1'b1};
    vecs[6]  = '{8'h22, 1'b0, 6'd0, 32'h0,        1'b1};
    vecs[7]  = '{8'h10, 1'b1, 6'd1, 32'h10220004, 1'b1};
    vecs[8]  = '{8'h00, 1'b0, 6'd0, 32'h0,        1'b1};
    vecs[9]  = '{8'h00, 1'b0, 6'd0, 32'h0,        1'b1};
    vecs[10] = '{8'h00, 1'b0, 6'd0, 32'h0,        1'b1};
    vecs[11] = '{8'hFC, 1'b1, 6'd2, 32'hFC000000, 1'b0};
    vecs[12] = '{8'h07, 1'b0, 6'd0, 32'h0,        1'b0};

    repeat (3) @(posedge clk);
    #1 check("reset_outs", outs(), 64'h0);
    @(posedge clk);
    #1 i_reset = 1'b1;
    #1 check("reset_state_load", o_busy, 1);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 i_rx_done = 1'b1; i_rx_data = vecs[i].rx;
      #1 check($sformatf("load%0d_we", i), o_imem_we, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("load%0d_addr", i), o_imem_addr, vecs[i].addr);
        check($sformatf("load%0d_data", i), o_imem_wdata, vecs[i].data);
      end
      @(posedge clk);
      #1 i_rx_done = 1'b0;
      check($sformatf("load%0d_busy", i), o_busy, vecs[i].busy);
    end
    check("load_write_count", we_addr.size(), 3);

    // RUN for 50 cycles, halt, dump, then FINISHED
    tx_q.delete(); en_cnt = 0;
    send_byte(8'h00);
    repeat (50) @(posedge clk);
    #1 i_halt = 1'b1;
    n = 0;
    while (tx_q.size() < 10 && n < 1000) begin @(negedge clk); n++; end
    send_byte(8'h01);
    wait_idle("run_dump_done", 3000);
    check("run_enable_cycles", en_cnt, 50);
    check_dump("run", 260);
    check("run_pc_word", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'h38);
    check("run_overlap", overlap, 0);
    send_byte(8'h01);
    repeat (3) @(posedge clk);
    #1 check("finished_busy", o_busy, 0);
    check("finished_no_enable", en_cnt, 50);

    // two single steps from a fresh load
    i_halt = 1'b0;
    reset_pulse();
    for (int i = 0; i < 12; i++) send_byte(vecs[i].rx);
    #1 check("reload_wait_cmd", o_busy, 0);
    en_cnt = 0;
    for (int s = 0; s < 2; s++) begin
      tx_q.delete();
      send_byte(8'h01);
      wait_idle($sformatf("step%0d_dump_done", s), 3000);
      check($sformatf("step%0d_enable", s), en_cnt, s + 1);
      check_dump($sformatf("step%0d", s), 260);
    end

    // slow handshake, then reset in the middle of the dump
    tx_q.delete(); overlap = 0; unstable = 0; tx_delay = 100;
    send_byte(8'h01);
    n = 0;
    while (tx_q.size() < 100 && n < 20000) begin @(negedge clk); n++; end
    check("hs_reached_100", tx_q.size() >= 100, 1);
    check("hs_stable", unstable, 0);
    check("hs_overlap", overlap, 0);
    check("hs_reg5", {tx_q[27], tx_q[26], tx_q[25], tx_q[24]}, 32'hDEADBEEF);
    bad = 0;
    for (int i = 0; i < 100 && i < tx_q.size(); i++) if (tx_q[i] !== exp_byte(i)) bad++;
    check("hs_bytes", bad, 0);
    #2 i_reset = 1'b0;
    #1 check("hs_reset_outs", outs(), 64'h0);
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b1;
    sz = tx_q.size();
    repeat (300) @(posedge clk);
    #1 check("hs_no_tx_after_reset", tx_q.size(), sz);
    check("hs_state_load", o_busy, 1);

    // partial word discarded by reset
    we_addr.delete(); we_data.delete();
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset_pulse();
    for (int i = 0; i < 4; i++) send_byte(vecs[i].rx);
    @(negedge clk);
    check("post_reset_writes", we_addr.size(), 1);
    check("post_reset_addr", we_addr[0], 0);
    check("post_reset_data", we_data[0], 32'h00221821);

    // IMEM_ADDR_W=2: four words fill memory without a halt opcode
    for (int i = 0; i < 16; i++) send_b(8'(i));
    check("b_full_wait_cmd", b_busy, 0);
    check("b_write_count", b_we_addr.size(), 4);
    bad = 0;
    for (int k = 0; k < 4 && k < b_we_addr.size(); k++)
      if (b_we_addr[k] !== 2'(k) || b_we_data[k] !== {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}) bad++;
    check("b_writes", bad, 0);
    send_b(8'h07);
    check("b_17th_no_write", b_we_addr.size(), 4);
    check("b_07_ignored", b_busy, 0);
    send_b(8'h01);
    check("b_step_accepted", b_busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/debug_unit_ctrl.md
DEBUG_UNIT_CTRL -- requirements
Module: debug_unit_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, CPU word width; DATA_WIDTH_UART, 8, UART byte width; IMEM_ADDR_W, 6, instruction-memory address width; NREGS, 32, register-file words dumped; NMEM, 32, data-memory words dumped.
REQ-002 SHALL have ports, one clock and asynchronous active-low reset:
- i_clock  in  1  sole clock
- i_reset  in  1  asynchronous, active-low reset
- i_rx_done  in  1  one-cycle pulse, UART byte received
- i_rx_data  in  8  received byte, valid with i_rx_done
- i_tx_done  in  1  one-cycle pulse, UART finished sending current byte
- o_tx_signal  out  1  one-cycle pulse, start UART transmit
- o_tx_data  out  8  byte to transmit
- o_imem_we  out  1  instruction-memory write strobe
- o_imem_addr  out  IMEM_ADDR_W  instruction-memory write address
- o_imem_wdata  out  32  instruction word
- o_cpu_enable  out  1  pipeline advance enable
- i_halt  in  1  halt instruction (opcode 6'b111111) has retired
- i_pc  in  32  current PC
- o_reg_addr  out  5  register-file read address
- i_reg_data  in  32  register-file read data, same-cycle
- o_mem_addr  out  5  data-memory read address
- i_mem_data  in  32  data-memory read data, same-cycle
- o_busy  out  1  high in any state except WAIT_CMD and FINISHED

Function
REQ-003 SHALL implement FSM states LOAD, WAIT_CMD, RUN, STEP, DUMP, FINISHED.
REQ-004 LOAD: each i_rx_done byte SHALL fill word bytes LSB first ([7:0], [15:8], [23:16], [31:24]), tracked by a 2-bit byte counter.
REQ-005 On the 4th byte, o_imem_we SHALL pulse one cycle with the assembled word and the current address; the address SHALL then increment.
REQ-006 If the written word has [31:26]==6'b111111, or the address written was 2^IMEM_ADDR_W-1, the FSM SHALL go to WAIT_CMD; the address does not wrap.
REQ-007 WAIT_CMD: rx byte 8'h00 -> RUN; 8'h01 -> STEP; any other byte is ignored and the FSM stays.
REQ-008 RUN: o_cpu_enable = ~i_halt (combinational); when i_halt is sampled high, the FSM goes to DUMP.
REQ-009 STEP: o_cpu_enable SHALL be high for exactly one cycle, then the FSM goes to DUMP.
REQ-010 DUMP SHALL transmit, in order: i_pc, registers 0..NREGS-1, memory words 0..NMEM-1; each word is sent LSB first; total 4*(1+NREGS+NMEM) = 260 bytes by default.
REQ-011 Per byte: o_tx_signal pulses one cycle; o_tx_data holds stable until i_tx_done; the next o_tx_signal comes no earlier than the cycle after i_tx_done.
REQ-012 o_reg_addr and o_mem_addr SHALL hold the word index being sent and stay stable for all 4 bytes of that word.
REQ-013 The PC value SHALL be captured at DUMP entry; register and memory words are read live, since the CPU is stalled in DUMP.
REQ-014 After the last byte's i_tx_done: if a halt was seen (RUN exit, or i_halt high during STEP), the FSM goes to FINISHED; otherwise it returns to WAIT_CMD.
REQ-015 FINISHED SHALL ignore all rx bytes; only reset leaves it.
REQ-016 o_cpu_enable SHALL be low in every state except RUN and the single STEP cycle.
REQ-017 Rx bytes arriving in RUN, STEP or DUMP SHALL be dropped.
REQ-018 i_tx_done outside DUMP SHALL be ignored.
REQ-019 When i_rx_done and i_tx_done occur in the same cycle, each SHALL be handled per the current state; neither is lost when that state consumes it.

Reset
REQ-020 Reset low SHALL asynchronously force: state LOAD; byte counter, word index and imem address to 0; halt flag clear.
REQ-021 While reset is low, every output SHALL be 0.
REQ-022 Reset mid-LOAD SHALL discard any partial word; reset mid-DUMP SHALL abort transmission, with no further o_tx_signal.

Verification
REQ-023 Load: send bytes 21 18 22 00 | 04 00 22 10 | 00 00 00 FC -> three o_imem_we pulses, addrs 0,1,2, data 32'h00221821, 32'h10220004, 32'hFC000000; then state WAIT_CMD.
REQ-024 Run: after load, send 8'h00; raise i_halt 50 cycles later -> o_cpu_enable high for exactly those 50 cycles; then 260 bytes with i_pc=32'h38 sent first as 38 00 00 00; then FINISHED.
REQ-025 Step: send 8'h01 twice, i_halt low -> exactly two single-cycle o_cpu_enable pulses; two 260-byte dumps; state WAIT_CMD after each.
REQ-026 Handshake: delay i_tx_done 100 cycles per byte -> o_tx_data stable for the full 100 cycles; one o_tx_signal per byte; reg 5 = 32'hDEADBEEF sent as EF BE AD DE at byte offsets 24..27.
REQ-027 Boundary: IMEM_ADDR_W=2 with 4 words and no halt opcode -> WAIT_CMD after the 4th write; a 17th byte produces no o_imem_we; byte 8'h07 in WAIT_CMD is ignored.
REQ-028 Reset: assert reset at byte 100 of a dump -> all outputs 0 immediately; after release, state LOAD and the next 4 bytes write imem addr 0.
